// File: rtl/out_logger_pkg.sv
// Shared encodings for the output logger: FSM states, ASCII constants, frame length.
package out_logger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam int         FRAME_BITS = 10;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_0 + {4'h0, nib};
    else             return ASCII_A + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// 8-bit synchronous FIFO with show-ahead read; push and pop on a full FIFO both succeed.
// Push into a full FIFO without a pop is ignored; pop on empty is ignored (no bypass).
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/out_logger.sv
// Logs each change of sap_out as "HH\n" over an 8N1 UART; start bit two cycles after the change.
// Changes queue in a small FIFO; a change arriving while it is full (and not popping) is dropped and flagged.
module out_logger
  import out_logger_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sap_out,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  tx_state_t     state;
  logic [7:0]    prev;
  logic [7:0]    data;
  logic [7:0]    cur_char;
  logic [1:0]    char_idx;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic          change, baud_last, last_char;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;

  assign change    = (prev != sap_out);
  assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign last_char = (char_idx == 2'd2);
  // Pop from IDLE, or straight out of the final stop bit so messages run back to back.
  assign fifo_pop  = !fifo_empty &&
                     ((state == ST_IDLE) || (state == ST_STOP && baud_last && last_char));
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (change),
    .din   (sap_out),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    cur_char = ASCII_LF;
    case (char_idx)
      2'd0:    cur_char = hex_ascii(data[7:4]);
      2'd1:    cur_char = hex_ascii(data[3:0]);
      default: cur_char = ASCII_LF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev     <= 8'h00;
      overflow <= 1'b0;
    end else begin
      prev <= sap_out;
      if (change && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

  // tx is set one bit ahead at each bit boundary so it stays a clean registered output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      data     <= 8'h00;
      char_idx <= 2'd0;
      baud_cnt <= '0;
      bit_cnt  <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            data     <= fifo_dout;
            char_idx <= 2'd0;
            baud_cnt <= '0;
            bit_cnt  <= 4'd0;
            tx       <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= 4'd1;
            tx       <= cur_char[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'(FRAME_BITS - 2)) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              tx <= cur_char[bit_cnt[2:0]];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= 4'd0;
            if (!last_char) begin
              char_idx <= char_idx + 2'd1;
              tx       <= 1'b0;
              state    <= ST_START;
            end else if (!fifo_empty) begin
              data     <= fifo_dout;
              char_idx <= 2'd0;
              tx       <= 1'b0;
              state    <= ST_START;
            end else begin
              char_idx <= 2'd0;
              state    <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_logger.sv
// Directed bench for out_logger with CLKS_PER_BIT=4, FIFO_DEPTH=4; decodes tx with a bench-side UART receiver.
module tb_out_logger;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [7:0] sap_out;
  logic       tx, busy, overflow;

  int checks;
  int passed;

  out_logger #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .sap_out  (sap_out),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] hc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Call at a negedge; returns at the negedge in the middle of the stop bit.
  task automatic uart_rx(output logic [7:0] d, output bit ok);
    int t;
    ok = 1'b1;
    d  = 8'h00;
    t  = 0;
    while (tx !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) ok = 1'b0;
    repeat (CPB/2) @(negedge clk);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      d[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic rx_expect(input string name, input logic [7:0] exp);
    logic [7:0] d;
    bit ok;
    uart_rx(d, ok);
    checks++;
    if (!ok || d !== exp)
      $display("FAIL %s: got byte %h (framing ok=%0d), expected %h", name, d, ok, exp);
    else passed++;
  endtask

  task automatic quiet_check(input string name, input int cycles);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0 || busy !== 1'b0)
      $display("FAIL %s: tx low for %0d cycles, busy=%b, expected 0 and 0", name, lows, busy);
    else passed++;
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    sap_out = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx, busy, overflow} !== 3'b100)
      $display("FAIL reset_state: tx/busy/ovf=%b, expected 100", {tx, busy, overflow});
    else passed++;
    reset = 1'b0;
    quiet_check("reset_quiet", 200);
  endtask

  task automatic test_basic;
    @(posedge clk); #1 sap_out = 8'h3C;
    @(negedge clk);
    checks++;
    if ({tx, busy} !== 2'b10) $display("FAIL basic_cycN: tx/busy=%b, expected 10", {tx, busy});
    else passed++;
    @(negedge clk);
    checks++;
    if ({tx, busy} !== 2'b11) $display("FAIL basic_cycN1: tx/busy=%b, expected 11", {tx, busy});
    else passed++;
    @(negedge clk);
    checks++;
    if (tx !== 1'b0) $display("FAIL basic_start_N2: tx=%b, expected 0", tx);
    else passed++;
    rx_expect("basic_c0", 8'h33);
    rx_expect("basic_c1", 8'h43);
    rx_expect("basic_lf", 8'h0A);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) $display("FAIL basic_busy_N121: busy=%b, expected 1", busy);
    else passed++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL basic_busy_N122: busy=%b, expected 0", busy);
    else passed++;
  endtask

  task automatic test_hold;
    @(posedge clk); #1 sap_out = 8'hAF;
    @(negedge clk);
    rx_expect("hold_c0", 8'h41);
    rx_expect("hold_c1", 8'h46);
    rx_expect("hold_lf", 8'h0A);
    quiet_check("hold_no_repeat", 380);
  endtask

  task automatic test_overflow;
    logic [7:0] vals [6];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    fork
      begin
        @(posedge clk); #1 sap_out = vals[0];
        for (int i = 1; i < 5; i++) begin
          repeat (3) @(posedge clk);
          #1 sap_out = vals[i];
        end
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) $display("FAIL ovf_before: overflow=%b, expected 0", overflow);
        else passed++;
        repeat (3) @(posedge clk);
        #1 sap_out = vals[5];
        repeat (2) @(negedge clk);
        checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_after: overflow=%b, expected 1", overflow);
        else passed++;
      end
      begin
        @(negedge clk);
        for (int m = 0; m < 5; m++) begin
          rx_expect("ovf_hi", hc(vals[m][7:4]));
          rx_expect("ovf_lo", hc(vals[m][3:0]));
          rx_expect("ovf_lf", 8'h0A);
        end
      end
    join
    quiet_check("ovf_no_sixth", 200);
    checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: overflow=%b, expected 1", overflow);
    else passed++;
  endtask

  task automatic test_reset_mid_frame;
    @(posedge clk); #1 sap_out = 8'h5A;
    repeat (2) @(negedge clk);
    rx_expect("rst_c0", 8'h35);
    repeat (10) @(negedge clk);
    reset   = 1'b1;
    sap_out = 8'h00;
    #1;
    checks++;
    if ({tx, busy, overflow} !== 3'b100)
      $display("FAIL rst_async: tx/busy/ovf=%b, expected 100", {tx, busy, overflow});
    else passed++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    quiet_check("rst_no_resume", 200);
  endtask

  task automatic test_push_on_pop;
    logic [7:0] vals [6];
    vals = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    fork
      begin
        @(posedge clk); #1 sap_out = vals[0];
        for (int i = 1; i < 5; i++) begin
          repeat (3) @(posedge clk);
          #1 sap_out = vals[i];
        end
        repeat (109) @(posedge clk);
        #1 sap_out = vals[5];
        repeat (2) @(negedge clk);
        checks++;
        if (overflow !== 1'b0) $display("FAIL pop_push_ovf: overflow=%b, expected 0", overflow);
        else passed++;
      end
      begin
        @(negedge clk);
        for (int m = 0; m < 6; m++) begin
          rx_expect("pp_hi", hc(vals[m][7:4]));
          rx_expect("pp_lo", hc(vals[m][3:0]));
          rx_expect("pp_lf", 8'h0A);
        end
      end
    join
    quiet_check("pp_drained", 100);
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    reset   = 1'b1;
    sap_out = 8'h00;
    test_reset;
    test_basic;
    test_hold;
    test_overflow;
    test_reset_mid_frame;
    test_push_on_pop;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
